// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit.
// Data accesses win by default, but a fetch that has waited too long takes the next grant.
module mem_port_arbiter #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             if_req_i,
   input  logic [WIDTH-1:0] if_addr_i,
   input  logic             if_flush_i,
   output logic             if_ack_o,
   output logic [WIDTH-1:0] if_data_o,
   output logic             if_stall_o,
   input  logic             ls_req_i,
   input  logic             ls_we_i,
   input  logic [WIDTH-1:0] ls_addr_i,
   input  logic [WIDTH-1:0] ls_wdata_i,
   output logic             ls_ack_o,
   output logic [WIDTH-1:0] ls_rdata_o,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic [WIDTH-1:0] mem_addr_o,
   output logic [WIDTH-1:0] mem_wdata_o,
   input  logic             mem_ack_i,
   input  logic [WIDTH-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      LS_BUSY = 2'd2
   } state_e;

   localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

   state_e           state_q, state_d;
   logic             squash_q, squash_d;
   logic [3:0]       streak_q, streak_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;

   logic ifAck;
   logic lsAck;
   logic decide;
   logic ifElig;
   logic lsElig;
   logic grantIf;
   logic grantLs;

   // A requester whose access is being acked this cycle still shows its old request,
   // so it is kept out of the decision; a flushed fetch is likewise not eligible.
   always_comb begin
      ifAck   = (state_q == IF_BUSY) & mem_ack_i & ~squash_q & ~if_flush_i;
      lsAck   = (state_q == LS_BUSY) & mem_ack_i;
      decide  = (state_q == IDLE) | mem_ack_i;
      ifElig  = if_req_i & ~if_flush_i & ~ifAck;
      lsElig  = ls_req_i & ~lsAck;
      grantIf = decide & ifElig & (~lsElig | (streak_q >= Limit));
      grantLs = decide & lsElig & ~grantIf;
   end

   always_comb begin
      state_d     = state_q;
      squash_d    = squash_q | ((state_q == IF_BUSY) & if_flush_i);
      streak_d    = streak_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (decide) begin
         squash_d  = 1'b0;
         mem_req_d = grantIf | grantLs;
         if (!if_req_i || grantIf) begin
            streak_d = 4'd0;
         end else if (grantLs && (streak_q < Limit)) begin
            streak_d = streak_q + 4'd1;
         end
         if (grantIf) begin
            state_d     = IF_BUSY;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
         end else if (grantLs) begin
            state_d     = LS_BUSY;
            mem_we_d    = ls_we_i;
            mem_addr_d  = ls_addr_i;
            mem_wdata_d = ls_wdata_i;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         squash_q    <= 1'b0;
         streak_q    <= 4'd0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         squash_q    <= squash_d;
         streak_q    <= streak_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign if_ack_o    = ifAck;
   assign ls_ack_o    = lsAck;
   assign if_stall_o  = if_req_i & ~ifAck;
   assign if_data_o   = mem_rdata_i;
   assign ls_rdata_o  = mem_rdata_i;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Cycle-by-cycle vector table for mem_port_arbiter; each row's expectations are queued
// when driven and popped when the outputs are sampled two time units later.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rstN;
   logic        ifReq, ifFlush, lsReq, lsWe, memAck;
   logic [31:0] ifAddr, lsAddr, lsWdata, memRdata;
   logic        ifAck, ifStall, lsAck, memReq, memWe;
   logic [31:0] ifData, lsRdata, memAddr, memWdata;

   int nVectors    = 0;
   int nMiscompares = 0;

   typedef struct {
      string       name;
      logic        rst;
      logic        ifReq;
      logic [31:0] ifAddr;
      logic        ifFlush;
      logic        lsReq;
      logic        lsWe;
      logic [31:0] lsAddr;
      logic [31:0] lsWdata;
      logic        memAck;
      logic [31:0] memRdata;
      logic        eIfAck;
      logic        eLsAck;
      logic        eStall;
      logic        eMemReq;
      logic        eMemWe;
      logic [31:0] eMemAddr;
      logic [31:0] eMemWdata;
   } vec_t;

   vec_t vecs[$];
   vec_t expQ[$];

   always #5 clk = ~clk;

   mem_port_arbiter #(.WIDTH(32), .STARVE_LIMIT(4)) dut (
      .clk_i(clk), .rst_ni(rstN),
      .if_req_i(ifReq), .if_addr_i(ifAddr), .if_flush_i(ifFlush),
      .if_ack_o(ifAck), .if_data_o(ifData), .if_stall_o(ifStall),
      .ls_req_i(lsReq), .ls_we_i(lsWe), .ls_addr_i(lsAddr), .ls_wdata_i(lsWdata),
      .ls_ack_o(lsAck), .ls_rdata_o(lsRdata),
      .mem_req_o(memReq), .mem_we_o(memWe), .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
      .mem_ack_i(memAck), .mem_rdata_i(memRdata)
   );

   task automatic compare(input string name, input string field,
                          input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s.%s: got %h, want %h", name, field, act, exp);
      end
   endtask

   task automatic addVec(input string name, input logic r,
                         input logic iq, input logic [31:0] ia, input logic fl,
                         input logic lq, input logic lw, input logic [31:0] la, input logic [31:0] lwd,
                         input logic ma, input logic [31:0] md,
                         input logic eia, input logic ela, input logic est, input logic emr,
                         input logic emw, input logic [31:0] emaddr, input logic [31:0] emwd);
      vec_t v;
      v.name = name;   v.rst = r;
      v.ifReq = iq;    v.ifAddr = ia;   v.ifFlush = fl;
      v.lsReq = lq;    v.lsWe = lw;     v.lsAddr = la;    v.lsWdata = lwd;
      v.memAck = ma;   v.memRdata = md;
      v.eIfAck = eia;  v.eLsAck = ela;  v.eStall = est;   v.eMemReq = emr;
      v.eMemWe = emw;  v.eMemAddr = emaddr; v.eMemWdata = emwd;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      rstN = v.rst;     ifReq = v.ifReq;  ifAddr = v.ifAddr; ifFlush = v.ifFlush;
      lsReq = v.lsReq;  lsWe = v.lsWe;    lsAddr = v.lsAddr; lsWdata = v.lsWdata;
      memAck = v.memAck; memRdata = v.memRdata;
      expQ.push_back(v);
      nVectors++;
   endtask

   task automatic checkOutput();
      vec_t e;
      #2;
      if (expQ.size() == 0) begin
         nMiscompares++;
         $display("[TB] FAIL scoreboard: got empty queue, want one entry");
      end else begin
         e = expQ.pop_front();
         compare(e.name, "if_ack", 32'(ifAck), 32'(e.eIfAck));
         compare(e.name, "ls_ack", 32'(lsAck), 32'(e.eLsAck));
         compare(e.name, "if_stall", 32'(ifStall), 32'(e.eStall));
         compare(e.name, "mem_req", 32'(memReq), 32'(e.eMemReq));
         if (e.eMemReq) begin
            compare(e.name, "mem_we", 32'(memWe), 32'(e.eMemWe));
            compare(e.name, "mem_addr", memAddr, e.eMemAddr);
            compare(e.name, "mem_wdata", memWdata, e.eMemWdata);
         end
         if (e.eIfAck) compare(e.name, "if_data", ifData, e.memRdata);
         if (e.eLsAck && !e.lsWe) compare(e.name, "ls_rdata", lsRdata, e.memRdata);
      end
   endtask

   initial begin
      rstN = 1'b0; ifReq = 1'b1; ifAddr = '0; ifFlush = 1'b0;
      lsReq = 1'b0; lsWe = 1'b0; lsAddr = '0; lsWdata = '0;
      memAck = 1'b0; memRdata = '0;

      // Reset state, with a fetch request visible to show if_stall follows if_req.
      repeat (2) @(posedge clk);
      @(negedge clk);
      nVectors++;
      compare("reset", "mem_req", 32'(memReq), 32'd0);
      compare("reset", "mem_we", 32'(memWe), 32'd0);
      compare("reset", "mem_addr", memAddr, 32'd0);
      compare("reset", "mem_wdata", memWdata, 32'd0);
      compare("reset", "if_stall", 32'(ifStall), 32'd1);
      compare("reset", "if_ack", 32'(ifAck), 32'd0);
      compare("reset", "ls_ack", 32'(lsAck), 32'd0);
      rstN = 1'b1; ifReq = 1'b0;

      //     name      rst ifReq ifAddr  fl  lsReq we lsAddr   lsWdata       ack rdata          eIf eLs eStl eReq eWe eAddr    eWdata
      addVec("idleAck", 1, 0, 32'h0,   0,  0, 0, 32'h0,   32'h0,        1, 32'hBAD00001,   0, 0, 0, 0, 0, 32'h0,   32'h0);
      addVec("fetch0",  1, 1, 32'h10,  0,  0, 0, 32'h0,   32'h0,        0, 32'h0,          0, 0, 1, 0, 0, 32'h0,   32'h0);
      addVec("fetch1",  1, 1, 32'h10,  0,  0, 0, 32'h0,   32'h0,        0, 32'h0,          0, 0, 1, 1, 0, 32'h10,  32'h0);
      addVec("fetch2",  1, 1, 32'h10,  0,  0, 0, 32'h0,   32'h0,        0, 32'h0,          0, 0, 1, 1, 0, 32'h10,  32'h0);
      addVec("fetch3",  1, 1, 32'h10,  0,  0, 0, 32'h0,   32'h0,        1, 32'h12345678,   1, 0, 0, 1, 0, 32'h10,  32'h0);
      addVec("fetch4",  1, 0, 32'h0,   0,  0, 0, 32'h0,   32'h0,        0, 32'h0,          0, 0, 0, 0, 0, 32'h0,   32'h0);
      addVec("write0",  1, 0, 32'h0,   0,  1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0,          0, 0, 0, 0, 0, 32'h0,   32'h0);
      addVec("write1",  1, 0, 32'h0,   0,  1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0,          0, 0, 0, 1, 1, 32'h100, 32'hDEADBEEF);
      addVec("write2",  1, 0, 32'h0,   0,  1, 1, 32'h100, 32'hDEADBEEF, 1, 32'hFFFFFFFF,   0, 1, 0, 1, 1, 32'h100, 32'hDEADBEEF);
      addVec("write3",  1, 0, 32'h0,   0,  0, 0, 32'h0,   32'h0,        0, 32'h0,          0, 0, 0, 0, 0, 32'h0,   32'h0);
      addVec("cont0",   1, 1, 32'h200, 0,  1, 0, 32'h300, 32'h0,        0, 32'h0,          0, 0, 1, 0, 0, 32'h0,   32'h0);
      addVec("cont1",   1, 1, 32'h200, 0,  1, 0, 32'h300, 32'h0,        0, 32'h0,          0, 0, 1, 1, 0, 32'h300, 32'h0);
      addVec("cont2",   1, 1, 32'h200, 0,  1, 0, 32'h300, 32'h0,        1, 32'h0000000A,   0, 1, 1, 1, 0, 32'h300, 32'h0);
      addVec("cont3",   1, 1, 32'h200, 0,  1, 0, 32'h304, 32'h0,        0, 32'h0,          0, 0, 1, 1, 0, 32'h200, 32'h0);
      addVec("cont4",   1, 1, 32'h200, 0,  1, 0, 32'h304, 32'h0,        1, 32'h0000000B,   1, 0, 0, 1, 0, 32'h200, 32'h0);
      addVec("cont5",   1, 1, 32'h204, 0,  1, 0, 32'h304, 32'h0,        0, 32'h0,          0, 0, 1, 1, 0, 32'h304, 32'h0);
      addVec("cont6",   1, 1, 32'h204, 0,  1, 0, 32'h304, 32'h0,        1, 32'h0000000C,   0, 1, 1, 1, 0, 32'h304, 32'h0);
      addVec("cont7",   1, 1, 32'h204, 0,  0, 0, 32'h0,   32'h0,        0, 32'h0,          0, 0, 1, 1, 0, 32'h204, 32'h0);
      addVec("cont8",   1, 1, 32'h204, 0,  0, 0, 32'h0,   32'h0,        1, 32'h0000000D,   1, 0, 0, 1, 0, 32'h204, 32'h0);
      addVec("cont9",   1, 0, 32'h0,   0,  0, 0, 32'h0,   32'h0,        0, 32'h0,          0, 0, 0, 0, 0, 32'h0,   32'h0);
      addVec("flush0",  1, 1, 32'h20,  0,  0, 0, 32'h0,   32'h0,        0, 32'h0,          0, 0, 1, 0, 0, 32'h0,   32'h0);
      addVec("flush1",  1, 1, 32'h20,  1,  0, 0, 32'h0,   32'h0,        0, 32'h0,          0, 0, 1, 1, 0, 32'h20,  32'h0);
      addVec("flush2",  1, 1, 32'h80,  0,  0, 0, 32'h0,   32'h0,        0, 32'h0,          0, 0, 1, 1, 0, 32'h20,  32'h0);
      addVec("flush3",  1, 1, 32'h80,  0,  0, 0, 32'h0,   32'h0,        1, 32'h0000000E,   0, 0, 1, 1, 0, 32'h20,  32'h0);
      addVec("flush4",  1, 1, 32'h80,  0,  0, 0, 32'h0,   32'h0,        1, 32'h0000000F,   1, 0, 0, 1, 0, 32'h80,  32'h0);
      addVec("flush5",  1, 0, 32'h0,   0,  0, 0, 32'h0,   32'h0,        0, 32'h0,          0, 0, 0, 0, 0, 32'h0,   32'h0);
      addVec("coinc0",  1, 1, 32'h40,  0,  0, 0, 32'h0,   32'h0,        0, 32'h0,          0, 0, 1, 0, 0, 32'h0,   32'h0);
      addVec("coinc1",  1, 1, 32'h40,  1,  1, 0, 32'h500, 32'h0,        1, 32'h00000011,   0, 0, 1, 1, 0, 32'h40,  32'h0);
      addVec("coinc2",  1, 0, 32'h0,   0,  1, 0, 32'h500, 32'h0,        1, 32'h00000022,   0, 1, 0, 1, 0, 32'h500, 32'h0);
      addVec("coinc3",  1, 0, 32'h0,   0,  0, 0, 32'h0,   32'h0,        0, 32'h0,          0, 0, 0, 0, 0, 32'h0,   32'h0);
      addVec("rstMid0", 1, 0, 32'h0,   0,  1, 1, 32'h600, 32'h55,       0, 32'h0,          0, 0, 0, 0, 0, 32'h0,   32'h0);
      addVec("rstMid1", 0, 0, 32'h0,   0,  1, 1, 32'h600, 32'h55,       0, 32'h0,          0, 0, 0, 1, 1, 32'h600, 32'h55);
      addVec("rstMid2", 1, 0, 32'h0,   0,  0, 0, 32'h0,   32'h0,        1, 32'h00000033,   0, 0, 0, 0, 0, 32'h0,   32'h0);
      addVec("rstMid3", 1, 0, 32'h0,   0,  0, 0, 32'h0,   32'h0,        0, 32'h0,          0, 0, 0, 0, 0, 32'h0,   32'h0);
      addVec("starve0", 1, 1, 32'h900, 0,  1, 0, 32'hA00, 32'h0,        0, 32'h0,          0, 0, 1, 0, 0, 32'h0,   32'h0);
      addVec("starve1", 1, 1, 32'h900, 1,  1, 0, 32'hA00, 32'h0,        1, 32'h00000001,   0, 1, 1, 1, 0, 32'hA00, 32'h0);
      addVec("starve2", 1, 1, 32'h900, 0,  1, 0, 32'hA04, 32'h0,        0, 32'h0,          0, 0, 1, 0, 0, 32'h0,   32'h0);
      addVec("starve3", 1, 1, 32'h900, 1,  1, 0, 32'hA04, 32'h0,        1, 32'h00000002,   0, 1, 1, 1, 0, 32'hA04, 32'h0);
      addVec("starve4", 1, 1, 32'h900, 0,  1, 0, 32'hA08, 32'h0,        0, 32'h0,          0, 0, 1, 0, 0, 32'h0,   32'h0);
      addVec("starve5", 1, 1, 32'h900, 1,  1, 0, 32'hA08, 32'h0,        1, 32'h00000003,   0, 1, 1, 1, 0, 32'hA08, 32'h0);
      addVec("starve6", 1, 1, 32'h900, 0,  1, 0, 32'hA0C, 32'h0,        0, 32'h0,          0, 0, 1, 0, 0, 32'h0,   32'h0);
      addVec("starve7", 1, 1, 32'h900, 1,  1, 0, 32'hA0C, 32'h0,        1, 32'h00000004,   0, 1, 1, 1, 0, 32'hA0C, 32'h0);
      addVec("starve8", 1, 1, 32'h900, 0,  1, 0, 32'hA10, 32'h0,        0, 32'h0,          0, 0, 1, 0, 0, 32'h0,   32'h0);
      addVec("starve9", 1, 1, 32'h900, 0,  1, 0, 32'hA10, 32'h0,        1, 32'h00000005,   1, 0, 0, 1, 0, 32'h900, 32'h0);
      addVec("starveA", 1, 0, 32'h0,   0,  1, 0, 32'hA10, 32'h0,        1, 32'h00000006,   0, 1, 0, 1, 0, 32'hA10, 32'h0);
      addVec("starveB", 1, 0, 32'h0,   0,  0, 0, 32'h0,   32'h0,        0, 32'h0,          0, 0, 0, 0, 0, 32'h0,   32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput();
      end

      // Reset during a write must also clear the registered address and data.
      @(negedge clk);
      lsReq = 1'b1; lsWe = 1'b1; lsAddr = 32'h700; lsWdata = 32'hA5A5A5A5;
      @(negedge clk);
      nVectors++;
      compare("rstWr", "mem_addr", memAddr, 32'h700);
      rstN = 1'b0;
      @(negedge clk);
      rstN = 1'b1; lsReq = 1'b0; lsWe = 1'b0; lsAddr = '0; lsWdata = '0;
      memAck = 1'b1; memRdata = 32'h77;
      #2;
      nVectors++;
      compare("rstWr", "mem_req", 32'(memReq), 32'd0);
      compare("rstWr", "mem_we", 32'(memWe), 32'd0);
      compare("rstWr", "mem_addr", memAddr, 32'd0);
      compare("rstWr", "mem_wdata", memWdata, 32'd0);
      compare("rstWr", "ls_ack", 32'(lsAck), 32'd0);
      compare("rstWr", "if_ack", 32'(ifAck), 32'd0);
      @(negedge clk);
      memAck = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
